fp_align_add: RTL and testbench

Front stage of the single-precision FP adder; sits directly upstream of the normalize/round stage.
- Unpacks two IEEE-754 binary32 operands and orders them by magnitude.
- Aligns the smaller mantissa, with a sticky bit, then adds or subtracts.
- Emits the 24-bit aligned result, exponent, sign and sticky bit that the normalize stage consumes.
- Two-stage pipeline with valid/ready flow control.

---
 rtl/fp_align_add_pkg.sv | 54 +++++
 rtl/fp_align_add_shift_sticky.sv | 23 ++
 rtl/fp_align_add.sv | 142 ++++++++++++++
 tb/tb_fp_align_add.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_align_add_pkg.sv
// Shared types and constants for the binary32 align/add front stage.
// The FP_SPECIAL_CASE_EN macro adds NaN/Inf flags to the stage payloads.
package fp_pkg;

  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned MANT_W    = MAN_W + 1;
  localparam int unsigned SUM_W     = MANT_W + 1;
  localparam int unsigned EXP_BIAS  = 127;
  localparam int unsigned SHIFT_SAT = 26;
  localparam int unsigned EXP_MAX   = 255;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Stage 1 -> stage 2 payload: ordered, aligned operands
  typedef struct packed {
    logic [MANT_W-1:0] manL;
    logic [MANT_W-1:0] shifted;
    logic [EXP_W-1:0]  expL;
    logic              sign;
    logic              effSub;
    logic              sticky;
`ifdef FP_SPECIAL_CASE_EN
    logic              isNan;
    logic              isInf;
`endif
  } s1_t;

  // Stage 2 payload: what the normalize stage consumes
  typedef struct packed {
    logic [MANT_W-1:0] result;
    logic [EXP_W-1:0]  exp;
    logic              sign;
    logic              sticky;
`ifdef FP_SPECIAL_CASE_EN
    logic              isNan;
    logic              isInf;
`endif
  } s2_t;

  // Denormals have a hidden 0 and behave as exponent 1
  function automatic logic [MANT_W-1:0] fullMan(input fp32_t x);
    return {(x.exp != '0), x.man};
  endfunction

  function automatic logic [EXP_W-1:0] effExp(input fp32_t x);
    return (x.exp == '0) ? EXP_W'(1) : x.exp;
  endfunction

endpackage

// File: rtl/fp_align_add_shift_sticky.sv
// Combinational mantissa right shifter with saturation and sticky collection.
module fp_shift_sticky
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] manIn,
  input  logic [EXP_W-1:0]  shiftAmt,
  output logic [MANT_W-1:0] manOut_c,
  output logic              sticky_c
);

  // Past SHIFT_SAT every bit lands in sticky; below it, mask the shifted-out bits
  always_comb begin
    manOut_c = '0;
    sticky_c = 1'b0;
    if (shiftAmt >= EXP_W'(SHIFT_SAT)) begin
      sticky_c = |manIn;
    end else begin
      manOut_c = manIn >> shiftAmt;
      sticky_c = |(manIn & ~({MANT_W{1'b1}} << shiftAmt));
    end
  end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage binary32 unpack/align and add/sub front end with valid/ready flow.
// Optional macro FP_SPECIAL_CASE_EN adds is_nan/is_inf outputs.
module fp_align_add
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              op_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] aligned_result,
  output logic [EXP_W-1:0]  exponent_out,
  output logic              aligned_sign,
  output logic              sticky_bit
`ifdef FP_SPECIAL_CASE_EN
  ,
  output logic              is_nan,
  output logic              is_inf
`endif
);

  fp32_t             opA, opB, opL, opS;
  logic              swap;
  logic              effSub;
  logic [EXP_W-1:0]  expL, expS, dExp;
  logic [MANT_W-1:0] manS, shifted;
  logic              shSticky;
  logic [SUM_W-1:0]  sum;
  logic              s1Valid, outValidQ, s2Ready;
  s1_t               s1D, s1Q;
  s2_t               s2D, s2Q;

  assign opA = fp32_t'(op_a);
  assign opB = fp32_t'(op_b);

  assign s2Ready  = !outValidQ || out_ready;
  assign in_ready = !s1Valid || s2Ready;

  // Order by raw {exp,man}; equal magnitudes keep A as the large operand
  always_comb begin
    swap   = {opB.exp, opB.man} > {opA.exp, opA.man};
    effSub = opA.sign ^ opB.sign ^ op_sub;
    opL    = swap ? opB : opA;
    opS    = swap ? opA : opB;
    expL   = effExp(opL);
    expS   = effExp(opS);
    dExp   = expL - expS;
    manS   = fullMan(opS);
  end

  fp_shift_sticky uShift (
    .manIn   (manS),
    .shiftAmt(dExp),
    .manOut_c(shifted),
    .sticky_c(shSticky)
  );

  always_comb begin
    s1D         = '0;
    s1D.manL    = fullMan(opL);
    s1D.shifted = shifted;
    s1D.expL    = expL;
    s1D.sign    = swap ? (opB.sign ^ op_sub) : opA.sign;
    s1D.effSub  = effSub;
    s1D.sticky  = shSticky;
`ifdef FP_SPECIAL_CASE_EN
    begin
      logic aInf, bInf, aNan, bNan;
      aInf = (opA.exp == EXP_W'(EXP_MAX)) && (opA.man == '0);
      bInf = (opB.exp == EXP_W'(EXP_MAX)) && (opB.man == '0);
      aNan = (opA.exp == EXP_W'(EXP_MAX)) && (opA.man != '0);
      bNan = (opB.exp == EXP_W'(EXP_MAX)) && (opB.man != '0);
      s1D.isNan = aNan || bNan || (aInf && bInf && effSub);
      s1D.isInf = !s1D.isNan && (aInf || bInf);
      if (s1D.isInf) s1D.sign = aInf ? opA.sign : (opB.sign ^ op_sub);
    end
`endif
  end

  // Add/sub; a carry shifts right once and folds the dropped bit into sticky
  always_comb begin
    sum = s1Q.effSub ? ({1'b0, s1Q.manL} - {1'b0, s1Q.shifted})
                     : ({1'b0, s1Q.manL} + {1'b0, s1Q.shifted});
    s2D        = '0;
    s2D.result = sum[MANT_W-1:0];
    s2D.exp    = s1Q.expL;
    s2D.sign   = s1Q.sign;
    s2D.sticky = s1Q.sticky;
    if (sum[SUM_W-1]) begin
      s2D.result = sum[SUM_W-1:1];
      s2D.exp    = s1Q.expL + EXP_W'(1);
      s2D.sticky = s1Q.sticky | sum[0];
    end
    if (sum == '0 && !s1Q.sticky) s2D = '0;
`ifdef FP_SPECIAL_CASE_EN
    if (s1Q.isNan) begin
      s2D        = '0;
      s2D.isNan  = 1'b1;
      s2D.result = {2'b11, {(MANT_W-2){1'b0}}};
      s2D.exp    = EXP_W'(EXP_MAX);
    end else if (s1Q.isInf) begin
      s2D       = '0;
      s2D.isInf = 1'b1;
      s2D.sign  = s1Q.sign;
      s2D.exp   = EXP_W'(EXP_MAX);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid   <= 1'b0;
      s1Q       <= '0;
      outValidQ <= 1'b0;
      s2Q       <= '0;
    end else begin
      if (in_ready) begin
        s1Valid <= in_valid;
        if (in_valid) s1Q <= s1D;
      end
      if (s2Ready) begin
        outValidQ <= s1Valid;
        if (s1Valid) s2Q <= s2D;
      end
    end
  end

  assign out_valid      = outValidQ;
  assign aligned_result = s2Q.result;
  assign exponent_out   = s2Q.exp;
  assign aligned_sign   = s2Q.sign;
  assign sticky_bit     = s2Q.sticky;
`ifdef FP_SPECIAL_CASE_EN
  assign is_nan = s2Q.isNan;
  assign is_inf = s2Q.isInf;
`endif

endmodule

// File: tb/tb_fp_align_add.sv
// Directed scoreboard bench for fp_align_add (default and FP_SPECIAL_CASE_EN builds).
module tb_fp_align_add;

  logic        clk, rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic [23:0] aligned_result;
  logic [7:0]  exponent_out;
  logic        aligned_sign, sticky_bit;
`ifdef FP_SPECIAL_CASE_EN
  logic        is_nan, is_inf;
`endif

  typedef struct {
    int          id;
    logic [23:0] res;
    logic [7:0]  exp;
    logic        sign;
    logic        sticky;
    logic        nan;
    logic        inf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   txId   = 0;

  fp_align_add dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .aligned_result(aligned_result), .exponent_out(exponent_out),
    .aligned_sign(aligned_sign), .sticky_bit(sticky_bit)
`ifdef FP_SPECIAL_CASE_EN
    , .is_nan(is_nan), .is_inf(is_inf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s (tx %0d): observed 0x%0h expected 0x%0h", tag, id, obs, want);
  endtask

  // Drive one pair, hold until accepted, record what should come out
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [23:0] res, input logic [7:0] e, input logic s,
                      input logic st, input logic nan, input logic inf);
    exp_t x;
    bit   done = 0;
    op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        x = '{txId, res, e, s, st, nan, inf};
        q.push_back(x);
        txId++;
        done = 1;
      end
    end
    if (!done) chk("send_timeout", txId, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare every handshaken result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $error("FAIL unexpected_output: observed result 0x%0h expected none", aligned_result);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("result", x.id, 32'(aligned_result), 32'(x.res));
        chk("exponent", x.id, 32'(exponent_out), 32'(x.exp));
        chk("sign", x.id, 32'(aligned_sign), 32'(x.sign));
        chk("sticky", x.id, 32'(sticky_bit), 32'(x.sticky));
`ifdef FP_SPECIAL_CASE_EN
        chk("is_nan", x.id, 32'(is_nan), 32'(x.nan));
        chk("is_inf", x.id, 32'(is_inf), 32'(x.inf));
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", -1, 32'(out_valid), 32'd0);
    chk("rst_result", -1, 32'(aligned_result), 32'd0);
    chk("rst_exponent", -1, 32'(exponent_out), 32'd0);
    chk("rst_sign_sticky", -1, 32'({aligned_sign, sticky_bit}), 32'd0);
    chk("rst_in_ready", -1, 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency: accepted now, valid two cycles later
    send(32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("latency_1cyc", -1, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_2cyc", -1, 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Back-to-back directed cases
    send(32'h3FC00000, 32'h3F400000, 1'b1, 24'h600000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'h30800000, 1'b0, 24'h800000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b1, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'hBF800000, 1'b0, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    send(32'hBF800000, 32'hBF800000, 1'b1, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 24'hC00000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'h40000000, 1'b1, 24'h400000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'h3E000001, 1'b0, 24'h900000, 8'd127, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h3F800001, 32'h3F800000, 1'b0, 24'h800000, 8'd128, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h7F000000, 32'h7F000000, 1'b0, 24'h800000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h00000001, 32'h00000001, 1'b0, 24'h000002, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FP_SPECIAL_CASE_EN
    send(32'h7F800000, 32'h3F800000, 1'b0, 24'h000000, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h7F800000, 32'h7F800000, 1'b1, 24'hC00000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'h3F800000, 32'h7F800000, 1'b1, 24'h000000, 8'd255, 1'b1, 1'b0, 1'b0, 1'b1);
    send(32'h7FC00000, 32'h3F800000, 1'b0, 24'hC00000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    send(32'h7F800000, 32'h3F800000, 1'b0, 24'h800000, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'h7F800000, 32'h7F800000, 1'b1, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Stall: two pairs fill the pipe, the third waits while outputs hold
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 24'hC00000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    op_a = 32'h3FC00000; op_b = 32'h3F400000; op_sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", i, 32'(in_ready), 32'd0);
      chk("stall_out_valid", i, 32'(out_valid), 32'd1);
      chk("stall_hold_result", i, 32'(aligned_result), 32'h800000);
      chk("stall_hold_exp", i, 32'(exponent_out), 32'd128);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h3F400000, 1'b1, 24'h600000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_stall", -1, 32'(q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with both stages full drops both pairs
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h40000000, 32'h3F800000, 1'b0, 24'hC00000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", -1, 32'(out_valid), 32'd0);
    chk("mid_rst_result", -1, 32'(aligned_result), 32'd0);
    chk("mid_rst_exponent", -1, 32'(exponent_out), 32'd0);
    chk("mid_rst_sign_sticky", -1, 32'({aligned_sign, sticky_bit}), 32'd0);
    chk("mid_rst_in_ready", -1, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_no_emit", -1, 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    send(32'h3FC00000, 32'h3F400000, 1'b1, 24'h600000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_final", -1, 32'(q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
